// File: rtl/bus_arbiter_rr4_pkg.sv
// Shared types and sizing helpers for the round-robin tristate bus arbiter.
// Holds the sequencer state encoding and a clog2 used to size counters and selects.
package bus_arbiter_rr4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A single requester still needs a one-bit select.
  function automatic int sel_width(input int n_req);
    return (clog2(n_req) < 1) ? 1 : clog2(n_req);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr4_rr_pick.sv
// Rotating-priority encoder: finds the first active request starting at ptr and wrapping.
module bus_arbiter_rr4_rr_pick
  import bus_arbiter_rr4_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int SEL_W = sel_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  int pos;

  // Scan from the farthest rotated slot back toward ptr so the nearest request wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (req[pos[SEL_W-1:0]]) begin
        any = 1'b1;
        idx = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin owner sequencer for the shared tristate bus: grants, holds, and inserts
// turnaround cycles so two drivers never overlap. All outputs come straight from flops.
module bus_arbiter_rr4
  import bus_arbiter_rr4_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int MAX_HOLD    = 8,
  parameter  int TURN_CYCLES = 1,
  localparam int SEL_W       = sel_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             bus_en,
  output logic             busy,
  output logic             preempt
);

  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam int TURN_W = clog2(TURN_CYCLES + 1);

  arb_state_t        state;
  logic [SEL_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic              arb_slot;
  logic              start_grant;
  logic              owner_done;
  logic [SEL_W-1:0]  next_ptr;

  bus_arbiter_rr4_rr_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Arbitration happens only from IDLE or on the last turnaround cycle, using the stored ptr.
  always_comb begin
    arb_slot    = (state == IDLE) ||
                  ((state == TURN) && (turn_cnt == TURN_W'(TURN_CYCLES)));
    start_grant = arb_slot && pick_any;
    owner_done  = !req[sel] || (hold_cnt == HOLD_W'(MAX_HOLD));
    next_ptr    = (sel == SEL_W'(N_REQ - 1)) ? '0 : sel + SEL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      grant    <= '0;
      sel      <= '0;
      bus_en   <= 1'b0;
      busy     <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      preempt <= 1'b0;
      if (start_grant) begin
        state    <= OWN;
        grant    <= N_REQ'(1) << pick_idx;
        sel      <= pick_idx;
        bus_en   <= 1'b1;
        busy     <= 1'b1;
        hold_cnt <= HOLD_W'(1);
        turn_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          OWN: begin
            if (owner_done) begin
              // Still requesting at exit means the hold limit forced the release.
              state    <= TURN;
              grant    <= '0;
              bus_en   <= 1'b0;
              preempt  <= req[sel];
              ptr      <= next_ptr;
              hold_cnt <= '0;
              turn_cnt <= TURN_W'(1);
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          TURN: begin
            if (turn_cnt == TURN_W'(TURN_CYCLES)) begin
              state    <= IDLE;
              busy     <= 1'b0;
              turn_cnt <= '0;
            end else begin
              turn_cnt <= turn_cnt + TURN_W'(1);
            end
          end
          default: begin
            state  <= IDLE;
            grant  <= '0;
            bus_en <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
